tmds_decoder: RTL and testbench

- Receive-side counterpart of tmds_encoder. Takes one 10-bit TMDS channel word per cycle from an external deserializer and recovers 8-bit video data, 2-bit control and the video-enable flag.
- Runs a word-alignment FSM that requests bit-slips from the deserializer until control tokens decode cleanly, then tracks lock.
- Used per channel in a future HDMI-input path feeding the camera/IIR pipeline.

---
 rtl/tmds_pkg.sv | 29 ++
 rtl/tmds_word_decode.sv | 24 ++
 rtl/tmds_decoder.sv | 148 ++++++++++++++
 tb/tb_tmds_decoder.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token constants, alignment FSM states and
// the control-token matcher used by the receive path.
package tmds_pkg;

  localparam logic [9:0] CTRL_TOKEN_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_TOKEN_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_TOKEN_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_TOKEN_11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH,
    SLIP,
    LOCKED
  } state_t;

  // Returns {is_ctrl, c1, c0}; only exact token matches count as control.
  function automatic logic [2:0] decode_ctrl(input logic [9:0] word);
    logic [2:0] result;
    case (word)
      CTRL_TOKEN_00: result = 3'b100;
      CTRL_TOKEN_01: result = 3'b101;
      CTRL_TOKEN_10: result = 3'b110;
      CTRL_TOKEN_11: result = 3'b111;
      default:       result = 3'b000;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/tmds_word_decode.sv
// Combinational decode of one 10-bit TMDS word into control and data fields.
module tmds_word_decode
  import tmds_pkg::*;
(
  input  logic [9:0] tmds,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [7:0] d;

  always_comb begin
    {is_ctrl, ctrl} = decode_ctrl(tmds);
    d = tmds[9] ? ~tmds[7:0] : tmds[7:0];
    data = '0;
    data[0] = d[0];
    // bit8 set means the transmitter used XOR chaining, clear means XNOR
    for (int unsigned i = 1; i < 8; i++) begin
      data[i] = tmds[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

endmodule

// File: rtl/tmds_decoder.sv
// TMDS channel receiver: word alignment via bit-slip requests, lock tracking
// and a single registered output stage for decoded data/control.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int unsigned CTRL_LOCK     = 16,
  parameter int unsigned SEARCH_WINDOW = 2048,
  parameter int unsigned SLIP_WAIT     = 8,
  parameter int unsigned LOSS_WINDOW   = 4096
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [9:0] tmds_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic [1:0] control_out,
  output logic       ve_out,
  output logic       valid_out,
  output logic       locked_out,
  output logic       bitslip_out
);

  localparam int unsigned GAP_MAX = (SEARCH_WINDOW > LOSS_WINDOW) ? SEARCH_WINDOW : LOSS_WINDOW;
  localparam int unsigned GAP_W   = $clog2(GAP_MAX) + 1;
  localparam int unsigned RUN_W   = $clog2(CTRL_LOCK + 1);
  localparam int unsigned SLIP_W  = $clog2(SLIP_WAIT + 1);

  state_t             state, state_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n, gap_inc;
  logic [RUN_W-1:0]   run_cnt, run_n, run_inc;
  logic [SLIP_W-1:0]  slip_cnt, slip_n, slip_inc;
  logic               slip_req;
  logic               update;

  logic               is_ctrl;
  logic [1:0]         ctrl;
  logic [7:0]         data;

  tmds_word_decode u_word_decode (
    .tmds    (tmds_in),
    .is_ctrl (is_ctrl),
    .ctrl    (ctrl),
    .data    (data)
  );

  assign gap_inc  = (gap_cnt  == '1) ? gap_cnt  : gap_cnt  + GAP_W'(1);
  assign run_inc  = (run_cnt  == '1) ? run_cnt  : run_cnt  + RUN_W'(1);
  assign slip_inc = (slip_cnt == '1) ? slip_cnt : slip_cnt + SLIP_W'(1);

  always_comb begin
    state_n  = state;
    gap_n    = gap_cnt;
    run_n    = run_cnt;
    slip_n   = slip_cnt;
    slip_req = 1'b0;
    case (state)
      SEARCH: begin
        if (valid_in) begin
          if (is_ctrl) begin
            gap_n = '0;
            if (run_inc >= RUN_W'(CTRL_LOCK)) begin
              state_n = LOCKED;
              run_n   = '0;
            end else begin
              run_n = run_inc;
            end
          end else begin
            run_n = '0;
            if (gap_inc >= GAP_W'(SEARCH_WINDOW)) begin
              state_n  = SLIP;
              gap_n    = '0;
              slip_n   = '0;
              slip_req = 1'b1;
            end else begin
              gap_n = gap_inc;
            end
          end
        end
      end
      SLIP: begin
        run_n = '0;
        gap_n = '0;
        if (slip_cnt >= SLIP_W'(SLIP_WAIT - 1)) begin
          state_n = SEARCH;
          slip_n  = '0;
        end else begin
          slip_n = slip_inc;
        end
      end
      LOCKED: begin
        // A token clears the gap first, so it always beats lock loss
        if (valid_in) begin
          if (is_ctrl) begin
            gap_n = '0;
          end else if (gap_inc >= GAP_W'(LOSS_WINDOW)) begin
            state_n = SEARCH;
            gap_n   = '0;
            run_n   = '0;
          end else begin
            gap_n = gap_inc;
          end
        end
      end
      default: begin
        state_n = SEARCH;
        gap_n   = '0;
        run_n   = '0;
        slip_n  = '0;
      end
    endcase
  end

  // Gate on the next state so the lock-completing token is itself emitted
  assign update = valid_in && (state_n == LOCKED);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= SEARCH;
      gap_cnt     <= '0;
      run_cnt     <= '0;
      slip_cnt    <= '0;
      bitslip_out <= 1'b0;
      valid_out   <= 1'b0;
      data_out    <= '0;
      control_out <= '0;
      ve_out      <= 1'b0;
    end else begin
      state       <= state_n;
      gap_cnt     <= gap_n;
      run_cnt     <= run_n;
      slip_cnt    <= slip_n;
      bitslip_out <= slip_req;
      valid_out   <= update;
      if (update) begin
        if (is_ctrl) begin
          ve_out      <= 1'b0;
          control_out <= ctrl;
        end else begin
          ve_out   <= 1'b1;
          data_out <= data;
        end
      end
    end
  end

  assign locked_out = (state == LOCKED);

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: alignment, decode, lock loss and reset.
module tb_tmds_decoder;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] DW  = 10'h1FF;  // data word decoding to 8'h01
  localparam int unsigned SW = 64;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [9:0] tmds_in;
  logic       valid_in;
  logic [7:0] data_out;
  logic [1:0] control_out;
  logic       ve_out;
  logic       valid_out;
  logic       locked_out;
  logic       bitslip_out;

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;
  int disp = 0;

  tmds_decoder #(
    .CTRL_LOCK     (16),
    .SEARCH_WINDOW (SW),
    .SLIP_WAIT     (8),
    .LOSS_WINDOW   (4096)
  ) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .tmds_in     (tmds_in),
    .valid_in    (valid_in),
    .data_out    (data_out),
    .control_out (control_out),
    .ve_out      (ve_out),
    .valid_out   (valid_out),
    .locked_out  (locked_out),
    .bitslip_out (bitslip_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [9:0] w, input logic v);
    tmds_in  = w;
    valid_in = v;
    @(posedge clk_in);
    #1;
    cycle_no++;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_data"}, 32'(data_out), 32'h0);
    chk({tag, "_ctrl"}, 32'(control_out), 32'h0);
    chk({tag, "_ve"}, 32'(ve_out), 32'h0);
    chk({tag, "_valid"}, 32'(valid_out), 32'h0);
    chk({tag, "_locked"}, 32'(locked_out), 32'h0);
    chk({tag, "_slip"}, 32'(bitslip_out), 32'h0);
  endtask

  // Deserializer model: word seen at bit offset k of a repeating 10-bit pattern
  function automatic logic [9:0] rot(input logic [9:0] w, input int unsigned k);
    logic [9:0] r;
    for (int unsigned j = 0; j < 10; j++) r[j] = w[(j + k) % 10];
    return r;
  endfunction

  // Reference DVI TMDS encoder with running disparity
  task automatic enc(input logic [7:0] d, output logic [9:0] q);
    logic [8:0] qm;
    logic       xn;
    int         n1, n1q, n0q;
    n1 = $countones(d);
    xn = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~xn;
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (disp == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp += qm[8] ? (n1q - n0q) : (n0q - n1q);
    end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += -2 * int'(!qm[8]) + n1q - n0q;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned off;
    int slips, first_slip, last_slip, lock_cycle, min_sep, max_sep, sep, seen;
    logic [9:0] w;

    rst_in = 1'b0;
    tmds_in = '0;
    valid_in = 1'b0;
    @(posedge clk_in); @(posedge clk_in); #1;
    chk_all_zero("reset");
    rst_in = 1'b1;

    // Alignment from a 3-bit rotated blanking stream
    off = 3; slips = 0; first_slip = 0; last_slip = 0; lock_cycle = 0;
    min_sep = 1_000_000; max_sep = 0; cycle_no = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(rot(T00, off), 1'b1);
      if (bitslip_out) begin
        if (slips == 0) first_slip = cycle_no;
        else begin
          sep = cycle_no - last_slip;
          if (sep < min_sep) min_sep = sep;
          if (sep > max_sep) max_sep = sep;
        end
        last_slip = cycle_no;
        slips++;
        off = (off + 1) % 10;
      end
      if (locked_out) begin
        lock_cycle = cycle_no;
        break;
      end
    end
    chk("align_slips", 32'(slips), 32'd7);
    chk("align_first_slip", 32'(first_slip), 32'(SW));
    chk("align_min_sep", 32'(min_sep), 32'(SW + 8));
    chk("align_max_sep", 32'(max_sep), 32'(SW + 8));
    chk("align_lock_delay", 32'(lock_cycle - last_slip), 32'd24);
    chk("align_locked", 32'(locked_out), 32'd1);
    chk("align_valid", 32'(valid_out), 32'd1);
    chk("align_ctrl", 32'(control_out), 32'd0);

    // Control decode after lock
    cyc(T01, 1'b1);
    chk("ctrl01_ctrl", 32'(control_out), 32'd1);
    chk("ctrl01_ve", 32'(ve_out), 32'd0);
    chk("ctrl01_valid", 32'(valid_out), 32'd1);

    // Encoder round trip over all byte values
    for (int b = 0; b < 256; b++) begin
      enc(8'(b), w);
      cyc(w, 1'b1);
      chk("rt_data", 32'(data_out), 32'(b));
      chk("rt_ve", 32'(ve_out), 32'd1);
      chk("rt_valid", 32'(valid_out), 32'd1);
    end
    chk("rt_ctrl_held", 32'(control_out), 32'd1);

    // Lock loss after LOSS_WINDOW token-free words
    cyc(T00, 1'b1);
    for (int i = 0; i < 4095; i++) cyc(DW, 1'b1);
    chk("loss_4095_locked", 32'(locked_out), 32'd1);
    chk("loss_4095_data", 32'(data_out), 32'h01);
    chk("loss_4095_valid", 32'(valid_out), 32'd1);
    cyc(DW, 1'b1);
    chk("loss_4096_locked", 32'(locked_out), 32'd0);
    chk("loss_4096_valid", 32'(valid_out), 32'd0);
    chk("loss_4096_slip", 32'(bitslip_out), 32'd0);
    chk("loss_data_held", 32'(data_out), 32'h01);

    // Relock, then a token on word 4096 keeps lock
    for (int i = 0; i < 15; i++) cyc(T00, 1'b1);
    chk("relock_15", 32'(locked_out), 32'd0);
    cyc(T00, 1'b1);
    chk("relock_16", 32'(locked_out), 32'd1);
    for (int i = 0; i < 4095; i++) cyc(DW, 1'b1);
    cyc(T10, 1'b1);
    chk("hold_locked", 32'(locked_out), 32'd1);
    chk("hold_ctrl", 32'(control_out), 32'd2);
    chk("hold_ve", 32'(ve_out), 32'd0);
    chk("hold_data", 32'(data_out), 32'h01);
    cyc(DW, 1'b1);
    chk("hold_next_locked", 32'(locked_out), 32'd1);
    chk("hold_next_ve", 32'(ve_out), 32'd1);

    // Asynchronous reset while locked
    rst_in = 1'b0;
    #1;
    chk_all_zero("rst_locked");
    @(posedge clk_in); #1;
    rst_in = 1'b1;

    // Lock with idle cycles between tokens
    for (int i = 0; i < 15; i++) begin
      cyc(T00, 1'b1);
      cyc(10'h000, 1'b0);
      chk("gap_idle_valid", 32'(valid_out), 32'd0);
    end
    chk("gap_15_locked", 32'(locked_out), 32'd0);
    cyc(T00, 1'b1);
    chk("gap_16_locked", 32'(locked_out), 32'd1);
    chk("gap_16_valid", 32'(valid_out), 32'd1);
    cyc(10'h000, 1'b0);
    chk("gap_after_valid", 32'(valid_out), 32'd0);
    chk("gap_after_locked", 32'(locked_out), 32'd1);

    // Reset while in SLIP, then a full fresh window before the next slip
    rst_in = 1'b0;
    #1;
    rst_in = 1'b1;
    seen = 0;
    for (int i = 0; i < int'(SW) - 1; i++) begin
      cyc(DW, 1'b1);
      if (bitslip_out) seen++;
    end
    chk("pre_slip_none", 32'(seen), 32'd0);
    cyc(DW, 1'b1);
    chk("slip_pulse", 32'(bitslip_out), 32'd1);
    cyc(DW, 1'b1);
    chk("slip_single_cycle", 32'(bitslip_out), 32'd0);
    rst_in = 1'b0;
    #1;
    chk_all_zero("rst_slip");
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    seen = 0;
    for (int i = 0; i < int'(SW) - 1; i++) begin
      cyc(DW, 1'b1);
      if (bitslip_out) seen++;
    end
    chk("post_rst_no_slip", 32'(seen), 32'd0);
    cyc(DW, 1'b1);
    chk("post_rst_slip", 32'(bitslip_out), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
